round_ctrl: RTL and testbench

ROUND_CTRL -- requirements
Module: round_ctrl

---
 rtl/pong_defs.sv | 32 +++
 rtl/score_counter.sv | 55 +++++
 rtl/round_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_round_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pong_defs.sv
// ---------------------------------------------------------------------------
// pong_defs -- shared definitions for the pong round controller.
//
// Contents:
//   TICKS_WAIT_DEF  default number of tick pulses in the pre-serve wait
//                   (364 x 11 ms, roughly 4 s)
//   WIN_SCORE_DEF   default score that ends a game
//   SCORE_W         width of each player's score
//   round_state_e   round FSM state encoding, also driven out on the debug
//                   state port (IDLE=0, WAIT=1, SERVE=2, PLAY=3, OVER=4)
//   cnt_width()     counter width for a modulus, at least 1 bit
// ---------------------------------------------------------------------------
package pong_defs;

    localparam int TICKS_WAIT_DEF = 364;
    localparam int WIN_SCORE_DEF  = 7;
    localparam int SCORE_W        = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_SERVE = 3'd2,
        ST_PLAY  = 3'd3,
        ST_OVER  = 3'd4
    } round_state_e;

    // ceil(log2(n)), but never zero bits so TICKS_WAIT = 1 still has a register.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/score_counter.sv
// ---------------------------------------------------------------------------
// score_counter -- one player's score.
//
// Clears to zero, increments by one on request and saturates at WIN_SCORE so
// the score can never wrap.
//
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    asynchronous active-high reset, forces the score to 0
//   clr_i    synchronous clear (new game); wins over inc_i
//   inc_i    add one point (ignored once WIN_SCORE is reached)
//   count_o  current score, unsigned
//   reach_o  1 when the next increment will make the score equal WIN_SCORE
// ---------------------------------------------------------------------------
module score_counter
    import pong_defs::*;
#(
    parameter int WIN_SCORE = WIN_SCORE_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               inc_i,
    output logic [SCORE_W-1:0] count_o,
    output logic               reach_o
);

    localparam logic [SCORE_W-1:0] WIN  = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] LAST = SCORE_W'(WIN_SCORE - 1);

    logic [SCORE_W-1:0] count_q;
    logic [SCORE_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != WIN)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    // Lets the FSM decide OVER in the same cycle as the scoring increment.
    assign reach_o = (count_q == LAST);

endmodule

// File: rtl/round_ctrl.sv
// ---------------------------------------------------------------------------
// round_ctrl -- pong round sequencing: idle, pre-serve wait, serve, play and
// game over, plus both players' scores.
//
// The timebase tick comes from an external tick generator; this block only
// counts tick pulses.
//
// Ports:
//   CLOCK_50     50 MHz system clock, all state on its rising edge
//   reset        asynchronous active-high global reset
//   tick         one-cycle timebase pulse
//   start        one-cycle new-game request (honoured in IDLE/OVER only)
//   pause        level; freezes play and wait timing, blocks start
//   point_left   one-cycle pulse, left player scored
//   point_right  one-cycle pulse, right player scored
//   ball_en      ball motion enable (PLAY and not paused)
//   serve        one-cycle serve pulse (the SERVE state)
//   serve_dir    0 = serve toward right, 1 = toward left
//   score_left   left score
//   score_right  right score
//   game_over    high while in OVER
//   winner       0 = left, 1 = right; meaningful while game_over = 1
//   state        current FSM state encoding (debug/display)
// ---------------------------------------------------------------------------
module round_ctrl
    import pong_defs::*;
#(
    parameter int TICKS_WAIT = TICKS_WAIT_DEF,
    parameter int WIN_SCORE  = WIN_SCORE_DEF
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic               pause,
    input  logic               point_left,
    input  logic               point_right,
    output logic               ball_en,
    output logic               serve,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               game_over,
    output logic               winner,
    output logic [2:0]         state
);

    localparam int             CW       = cnt_width(TICKS_WAIT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TICKS_WAIT - 1);

    round_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          win_q, win_d;

    logic          clr_scores;
    logic          inc_left;
    logic          inc_right;
    logic          reach_left;
    logic          reach_right;

    // ---------------------------------------------------------------
    // State register (plus the datapath registers the FSM steers)
    // ---------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            win_q   <= win_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        win_d      = win_q;
        clr_scores = 1'b0;
        inc_left   = 1'b0;
        inc_right  = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start && !pause) begin
                    clr_scores = 1'b1;
                    cnt_d      = '0;
                    dir_d      = 1'b0;
                    state_d    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (tick && !pause) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_SERVE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            // Serve is a single-cycle state and is not held by pause.
            ST_SERVE: begin
                state_d = ST_PLAY;
            end

            ST_PLAY: begin
                if (!pause) begin
                    if (point_left && point_right) begin
                        // Simultaneous points cancel: replay the rally.
                        state_d = ST_WAIT;
                    end else if (point_left) begin
                        inc_left = 1'b1;
                        dir_d    = 1'b1;
                        if (reach_left) begin
                            win_d   = 1'b0;
                            state_d = ST_OVER;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else if (point_right) begin
                        inc_right = 1'b1;
                        dir_d     = 1'b0;
                        if (reach_right) begin
                            win_d   = 1'b1;
                            state_d = ST_OVER;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Output decode
    // ---------------------------------------------------------------
    always_comb begin
        serve     = (state_q == ST_SERVE);
        ball_en   = (state_q == ST_PLAY) && !pause;
        game_over = (state_q == ST_OVER);
        state     = state_q;
    end

    assign serve_dir = dir_q;
    assign winner    = win_q;

    // ---------------------------------------------------------------
    // Score counters
    // ---------------------------------------------------------------
    score_counter #(
        .WIN_SCORE (WIN_SCORE)
    ) u_score_left (
        .clk_i   (CLOCK_50),
        .rst_i   (reset),
        .clr_i   (clr_scores),
        .inc_i   (inc_left),
        .count_o (score_left),
        .reach_o (reach_left)
    );

    score_counter #(
        .WIN_SCORE (WIN_SCORE)
    ) u_score_right (
        .clk_i   (CLOCK_50),
        .rst_i   (reset),
        .clr_i   (clr_scores),
        .inc_i   (inc_right),
        .count_o (score_right),
        .reach_o (reach_right)
    );

endmodule

// File: tb/tb_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_round_ctrl -- self-checking bench for round_ctrl with TICKS_WAIT=3 and
// WIN_SCORE=2. Directed round scenarios followed by random stimulus, all
// checked cycle by cycle against a behavioural model of the round rules.
// ---------------------------------------------------------------------------
module tb_round_ctrl;

    localparam int TW = 3;
    localparam int WS = 2;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       tick, start, pause, point_left, point_right;
    logic       ball_en, serve, serve_dir, game_over, winner;
    logic [3:0] score_left, score_right;
    logic [2:0] state;

    always #10 clk = ~clk;

    round_ctrl #(
        .TICKS_WAIT (TW),
        .WIN_SCORE  (WS)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .tick        (tick),
        .start       (start),
        .pause       (pause),
        .point_left  (point_left),
        .point_right (point_right),
        .ball_en     (ball_en),
        .serve       (serve),
        .serve_dir   (serve_dir),
        .score_left  (score_left),
        .score_right (score_right),
        .game_over   (game_over),
        .winner      (winner),
        .state       (state)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase numbers are the published state codes: 0 idle, 1 wait, 2 serve,
    // 3 play, 4 over.
    int m_st, m_ticks, m_sl, m_sr, m_dir, m_win;

    task automatic model_reset();
        m_st = 0; m_ticks = 0; m_sl = 0; m_sr = 0; m_dir = 0; m_win = 0;
    endtask

    task automatic model_step(input logic s, input logic t, input logic p,
                              input logic l, input logic r);
        if (m_st == 2) begin
            m_st = 3;
        end else if (!p) begin
            if ((m_st == 0 || m_st == 4) && s) begin
                m_sl = 0; m_sr = 0; m_ticks = 0; m_dir = 0; m_st = 1;
            end else if (m_st == 1 && t) begin
                m_ticks++;
                if (m_ticks == TW) begin
                    m_ticks = 0;
                    m_st    = 2;
                end
            end else if (m_st == 3 && (l || r)) begin
                m_st = 1;
                if (l && !r) begin
                    m_sl++;
                    m_dir = 1;
                    if (m_sl == WS) begin m_st = 4; m_win = 0; end
                end else if (r && !l) begin
                    m_sr++;
                    m_dir = 0;
                    if (m_sr == WS) begin m_st = 4; m_win = 1; end
                end
            end
        end
    endtask

    task automatic check_all();
        check("state",       state,       m_st);
        check("serve",       serve,       (m_st == 2));
        check("ball_en",     ball_en,     (m_st == 3) && !pause);
        check("game_over",   game_over,   (m_st == 4));
        check("winner",      winner,      m_win);
        check("serve_dir",   serve_dir,   m_dir);
        check("score_left",  score_left,  m_sl);
        check("score_right", score_right, m_sr);
    endtask

    // ---------------- driver tasks ----------------
    // Entered at a falling edge; leaves at the next falling edge with the
    // pulse inputs returned to 0 and pause left as driven.
    task automatic drive_cycle(input logic s, input logic t, input logic p,
                               input logic l, input logic r);
        start = s; tick = t; pause = p; point_left = l; point_right = r;
        #1;
        check_all();
        model_step(s, t, p, l, r);
        @(posedge clk);
        #1;
        start = 1'b0; tick = 1'b0; point_left = 1'b0; point_right = 1'b0;
        @(negedge clk);
    endtask

    // Reset asserted away from the clock edge; outputs must clear at once.
    task automatic do_reset();
        start = 1'b0; tick = 1'b0; point_left = 1'b0; point_right = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle();
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic go_play();
        for (int i = 0; i < TW; i++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; tick = 1'b0; start = 1'b0; pause = 1'b0;
        point_left = 1'b0; point_right = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();
        check("rst_idle", state, 3'd0);

        // start, three ticks -> one-cycle serve, then ball moves
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("start_to_wait", state, 3'd1);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("no_serve_early", serve, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("serve_after_3rd", serve, 1'b1);
        idle();
        check("ball_en_next", ball_en, 1'b1);
        check("serve_one_cycle", serve, 1'b0);
        check("serve_dir_right", serve_dir, 1'b0);

        // right wins 2-0
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("sr_one", score_right, 4'd1);
        go_play();
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("sr_two", score_right, 4'd2);
        check("over_state", state, 3'd4);
        check("over_flag", game_over, 1'b1);
        check("winner_right", winner, 1'b1);
        check("over_ball_off", ball_en, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("sr_saturate", score_right, 4'd2);

        // start in OVER clears the game
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("restart_sr", score_right, 4'd0);
        check("restart_wait", state, 3'd1);

        // paused ticks do not count
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pause_held_wait", state, 3'd1);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pause_then_serve", serve, 1'b1);
        idle();

        // start during PLAY has no effect
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("start_in_play", state, 3'd3);

        // simultaneous points: no score, back to WAIT, direction kept
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("both_wait", state, 3'd1);
        check("both_sl", score_left, 4'd0);
        go_play();
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("left_dir", serve_dir, 1'b1);
        go_play();
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("both_dir_kept", serve_dir, 1'b1);
        check("both_sl_kept", score_left, 4'd1);

        // reset mid-PLAY aborts; only start leaves IDLE
        go_play();
        do_reset();
        check("rst_sl", score_left, 4'd0);
        check("rst_dir", serve_dir, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_stays", state, 3'd0);

        // random play
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                drive_cycle($urandom_range(0, 15) == 0,
                            $urandom_range(0, 1) == 0,
                            $urandom_range(0, 7) == 0,
                            $urandom_range(0, 5) == 0,
                            $urandom_range(0, 5) == 0);
            end
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
